// File: rtl/bcd2bin_serial.sv
// bcd2bin_serial: serial BCD-to-binary converter (reverse double-dabble).
// A handshake captures DIGITS packed BCD digits. The block then shifts
// {bcd_reg, bin_reg} right once per cycle for BIN_W cycles, and after each
// shift it subtracts 3 from every BCD digit that is >= 8. The result is held
// until the consumer takes it.
// Optional macro BCD2BIN_CHECK_EN: builds an input digit check. When a captured
// digit is > 9, the block skips the conversion and reports err=1 with bin_out=0.
module bcd2bin_serial #(
  parameter int DIGITS = 3,
  parameter int BIN_W  = 10
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [4*DIGITS-1:0]   bcd_in,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [BIN_W-1:0]      bin_out,
  output logic                  err
);

  localparam int CNT_W = $clog2(BIN_W + 1);
  localparam logic [CNT_W-1:0] LAST_IT = CNT_W'(BIN_W - 1);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] CONV = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  logic [1:0]          state;
  logic [4*DIGITS-1:0] bcd_reg;
  logic [BIN_W-1:0]    bin_reg;
  logic [CNT_W-1:0]    cnt;
  logic                accept;

  // After the right shift, a digit >= 8 has absorbed a half-weight bit from
  // the digit above. Subtracting 3 restores a valid base-10 digit.
  function automatic logic [4*DIGITS-1:0] adjust_digits(input logic [4*DIGITS-1:0] v);
    logic [4*DIGITS-1:0] r;
    r = v;
    for (int i = 0; i < DIGITS; i++) begin
      if (v[4*i+3]) r[4*i +: 4] = v[4*i +: 4] - 4'd3;
    end
    return r;
  endfunction

`ifdef BCD2BIN_CHECK_EN
  // True when any packed digit lies outside 0..9.
  function automatic logic has_bad_digit(input logic [4*DIGITS-1:0] v);
    logic bad;
    bad = 1'b0;
    for (int i = 0; i < DIGITS; i++) begin
      if (v[4*i +: 4] > 4'd9) bad = 1'b1;
    end
    return bad;
  endfunction
`endif

  assign accept    = in_valid && (state == IDLE);
  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);
  assign bin_out   = bin_reg;

  // Control FSM, iteration counter and binary shift register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      cnt     <= '0;
      bin_reg <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            bin_reg <= '0;
            cnt     <= '0;
`ifdef BCD2BIN_CHECK_EN
            state   <= has_bad_digit(bcd_in) ? DONE : CONV;
`else
            state   <= CONV;
`endif
          end
        end
        CONV: begin
          bin_reg <= {bcd_reg[0], bin_reg[BIN_W-1:1]};
          cnt     <= cnt + CNT_W'(1);
          if (cnt == LAST_IT) state <= DONE;
        end
        DONE: begin
          if (out_ready) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // BCD shift register. It is pure data and is only meaningful after a capture.
  always_ff @(posedge clk) begin
    if (accept) begin
      bcd_reg <= bcd_in;
    end else if (state == CONV) begin
      bcd_reg <= adjust_digits(bcd_reg >> 1);
    end
  end

`ifdef BCD2BIN_CHECK_EN
  logic err_reg;

  // Record the digit-check verdict for the value just captured.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_reg <= 1'b0;
    end else if (accept) begin
      err_reg <= has_bad_digit(bcd_in);
    end
  end

  assign err = err_reg;
`else
  assign err = 1'b0;
`endif

endmodule

// File: doc/bcd2bin_serial.md
BCD2BIN_SERIAL -- requirements
Module: bcd2bin_serial

Interface
REQ-001 SHALL have parameter DIGITS, default 3: number of packed BCD digits on input.
REQ-002 SHALL have parameter BIN_W, default 10: binary result width; must satisfy 2^BIN_W >= 10^DIGITS.
REQ-003 SHALL have port clk  input  1  system clock; all state changes on its rising edge.
REQ-004 SHALL have port rst_n  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port in_valid  input  1  bcd_in holds a value to convert.
REQ-006 SHALL have port in_ready  output  1  block can accept a new value.
REQ-007 SHALL have port bcd_in  input  4*DIGITS  packed BCD; digit 0 is bits [3:0].
REQ-008 SHALL have port out_valid  output  1  bin_out and err hold a finished result.
REQ-009 SHALL have port out_ready  input  1  consumer takes the result.
REQ-010 SHALL have port bin_out  output  BIN_W  unsigned binary result.
REQ-011 SHALL have port err  output  1  captured input contained a digit > 9; qualified by out_valid.

Function
REQ-012 SHALL implement three FSM states: IDLE, CONV, DONE.
REQ-013 In IDLE, in_ready SHALL be 1 and out_valid 0; in any other state in_ready SHALL be 0.
REQ-014 An input handshake is in_valid && in_ready at a rising edge; on it the block SHALL capture bcd_in into a BCD shift register, clear the binary shift register and the iteration counter, and enter CONV.
REQ-015 in_valid and bcd_in SHALL be ignored outside IDLE; bcd_in changes after capture SHALL NOT affect the result.
REQ-016 Each CONV cycle SHALL shift the concatenation {bcd_reg, bin_reg} right by one bit.
REQ-017 In the same cycle, after the shift, it SHALL subtract 3 from every 4-bit BCD digit whose value is >= 8.
REQ-018 CONV SHALL perform exactly BIN_W iterations, then enter DONE; out_valid SHALL be 1 exactly BIN_W cycles after the accepting edge.
REQ-019 In DONE, out_valid SHALL be 1 and bin_out and err SHALL be stable until out_ready is sampled 1; the block then SHALL return to IDLE.
REQ-020 out_ready asserted together with in_valid in DONE SHALL NOT accept the new input in that cycle; the minimum period between accepts is BIN_W+2 cycles.
REQ-021 bin_out SHALL reflect the binary register directly with no extra output latency; the iteration counter SHALL be ceil(log2(BIN_W+1)) bits wide and SHALL NOT wrap during CONV.

Reset
REQ-022 On rst_n low, regardless of clk, SHALL enter IDLE: in_ready=1, out_valid=0, bin_out=0, err=0, counter=0.
REQ-023 Reset asserted during CONV or DONE SHALL abort the conversion; the result SHALL be discarded and SHALL NOT be presented after release.
REQ-024 After rst_n release, the first rising edge SHALL be able to accept input.

Configuration
REQ-025 With macro BCD2BIN_CHECK_EN defined, capture SHALL test every digit; if any digit is > 9, the block SHALL skip CONV, go directly to DONE with bin_out=0 and err=1, and otherwise set err=0.
REQ-026 Without BCD2BIN_CHECK_EN, err SHALL be constant 0, no digit check SHALL be built, and invalid digits SHALL undergo the normal BIN_W-cycle conversion with a deterministic but unspecified result.

Verification
REQ-027 Accept bcd_in=12'h999, out_ready=1 -> out_valid 10 cycles later, bin_out=999 (10'h3E7), err=0.
REQ-028 Accept 12'h000, then 12'h255 -> bin_out=0, then bin_out=255, with out_valid pulsing once per result.
REQ-029 Accept 12'h407, hold out_ready=0 for 20 cycles -> out_valid stays 1, bin_out=407 stable, in_ready=0, new in_valid ignored; out_ready=1 -> IDLE the next cycle.
REQ-030 With BCD2BIN_CHECK_EN, accept 12'h1A3 -> out_valid 1 cycle after accept, err=1, bin_out=0; without the macro, err=0 after 10 cycles.
REQ-031 Assert rst_n=0 asynchronously at iteration 5 of converting 12'h512 -> outputs immediately at reset values; after release, accept 12'h042 -> bin_out=42 with no stale result.
REQ-032 Sweep all 1000 valid inputs 000..999 with random out_ready back-pressure -> every bin_out equals the decimal value and err=0.
